// File: rtl/dram_arb_pkg.sv
// Shared types and constants for the two-client DRAM AXI-lite arbiter.
package dram_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AW,
        ST_W,
        ST_B,
        ST_DONE
    } state_e;

    localparam int unsigned DRAM_DEPTH      = 8192;
    localparam int unsigned TIMEOUT_DEFAULT = 1023;
    localparam logic [1:0]  RESP_OKAY       = 2'b00;

endpackage

// File: rtl/dram_arb_rr.sv
// Two-way round-robin picker; the priority pointer register lives in the parent.
module dram_arb_rr (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic       gnt_id,
    output logic       gnt_valid
);

    always_comb begin
        gnt_valid = |req;
        gnt_id    = (req == 2'b11) ? ptr : req[1];
    end

endmodule

// File: rtl/dram_axi_arbiter.sv
// Shares one AXI-lite DRAM port between two req/done clients, one transaction
// at a time, with address range check and a per-handshake watchdog.
module dram_axi_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned DRAM_DEPTH = dram_arb_pkg::DRAM_DEPTH,
    parameter int unsigned TIMEOUT    = dram_arb_pkg::TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          in_req,
    input  logic [1:0]          in_write,
    input  logic [2*ADDR_W-1:0] in_addr,
    input  logic [2*DATA_W-1:0] in_wdata,
    output logic [1:0]          out_done,
    output logic [DATA_W-1:0]   out_rdata,
    output logic                out_err,
    output logic                AR_VALID,
    output logic [ADDR_W-1:0]   AR_ADDR,
    input  logic                AR_READY,
    input  logic                R_VALID,
    input  logic [DATA_W-1:0]   R_DATA,
    input  logic [1:0]          R_RESP,
    output logic                R_READY,
    output logic                AW_VALID,
    output logic [ADDR_W-1:0]   AW_ADDR,
    input  logic                AW_READY,
    output logic                W_VALID,
    output logic [DATA_W-1:0]   W_DATA,
    input  logic                W_READY,
    input  logic                B_VALID,
    input  logic [1:0]          B_RESP,
    output logic                B_READY
);

    import dram_arb_pkg::*;

    localparam int unsigned    CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DRAM_DEPTH);

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                id_q, id_d;
    logic                write_q, write_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic                gnt_id;
    logic                gnt_valid;
    logic                sel_write;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                is_wait;
    logic                hs_in;

    dram_arb_rr u_rr (
        .req       (in_req),
        .ptr       (ptr_q),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        sel_write = gnt_id ? in_write[1]               : in_write[0];
        sel_addr  = gnt_id ? in_addr[2*ADDR_W-1:ADDR_W] : in_addr[ADDR_W-1:0];
        sel_wdata = gnt_id ? in_wdata[2*DATA_W-1:DATA_W] : in_wdata[DATA_W-1:0];
    end

    // The handshake input awaited in the current state drives both the
    // transition and the shared watchdog.
    always_comb begin
        is_wait = 1'b1;
        hs_in   = 1'b0;
        case (state_q)
            ST_AR:   hs_in = AR_READY;
            ST_R:    hs_in = R_VALID;
            ST_AW:   hs_in = AW_READY;
            ST_W:    hs_in = W_READY;
            ST_B:    hs_in = B_VALID;
            default: is_wait = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = '0;

        if (is_wait && !hs_in) begin
            if (cnt_q == CNT_MAX) begin
                err_d   = 1'b1;
                state_d = ST_DONE;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        id_d    = gnt_id;
                        write_d = sel_write;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                        if (sel_addr >= DEPTH_A) begin
                            err_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            err_d   = 1'b0;
                            state_d = sel_write ? ST_AW : ST_AR;
                        end
                    end
                end
                ST_AR: state_d = ST_R;
                ST_R: begin
                    rdata_d = R_DATA;
                    err_d   = (R_RESP != RESP_OKAY);
                    state_d = ST_DONE;
                end
                ST_AW: state_d = ST_W;
                ST_W:  state_d = ST_B;
                ST_B: begin
                    rdata_d = '0;
                    err_d   = (B_RESP != RESP_OKAY);
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    ptr_d   = ~id_q;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode only from flops, so nothing is combinational from inputs.
    always_comb begin
        AR_VALID  = (state_q == ST_AR);
        R_READY   = (state_q == ST_R);
        AW_VALID  = (state_q == ST_AW);
        W_VALID   = (state_q == ST_W);
        B_READY   = (state_q == ST_B);
        AR_ADDR   = AR_VALID ? addr_q  : '0;
        AW_ADDR   = AW_VALID ? addr_q  : '0;
        W_DATA    = W_VALID  ? wdata_q : '0;
        out_done  = '0;
        out_err   = 1'b0;
        if (state_q == ST_DONE) begin
            out_done = id_q ? 2'b10 : 2'b01;
            out_err  = err_q;
        end
        out_rdata = rdata_q;
    end

endmodule
